// File: rtl/motor_step_driver.sv
// Two-axis stepper driver: tick-paced stepping of theta (clamped 0..180 deg)
// and phi (wrapping 0..359 deg) with registered coil phases and step pulses.
// Build option: define HALF_STEP_EN for the 8-entry half-step sequence;
// the default build uses the 4-entry full-step sequence.
module motor_step_driver #(
    parameter int unsigned CLK_DIV       = 50000,
    parameter int unsigned STEPS_PER_DEG = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  cmd_theta_pos,
    input  logic [1:0]  cmd_theta_neg,
    input  logic [1:0]  cmd_phi_pos,
    input  logic [1:0]  cmd_phi_neg,
    output logic [3:0]  coil_theta,
    output logic [3:0]  coil_phi,
    output logic        step_theta,
    output logic        step_phi,
    output logic [15:0] theta_actual,
    output logic [15:0] phi_actual,
    output logic        limit_theta
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
`ifdef HALF_STEP_EN
    localparam int unsigned IDX_W = 3;
`else
    localparam int unsigned IDX_W = 2;
`endif
    localparam int unsigned SUB_W   = (STEPS_PER_DEG > 1) ? $clog2(STEPS_PER_DEG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEPS_PER_DEG - 1);
    localparam logic [15:0]      THETA_MAX = 16'd180;
    localparam logic [15:0]      PHI_LAST  = 16'd359;

    // Coil pattern lookup; the phase count is a power of two so the index wraps naturally.
    function automatic logic [3:0] pattern(input logic [IDX_W-1:0] idx);
`ifdef HALF_STEP_EN
        case (idx)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1100;
            3'd2:    pattern = 4'b0100;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0010;
            3'd5:    pattern = 4'b0011;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
`else
        case (idx)
            2'd0:    pattern = 4'b1100;
            2'd1:    pattern = 4'b0110;
            2'd2:    pattern = 4'b0011;
            default: pattern = 4'b1001;
        endcase
`endif
    endfunction

    logic [CNT_W-1:0] tick_cnt;
    logic [IDX_W-1:0] th_idx, ph_idx, th_idx_n, ph_idx_n;
    logic [SUB_W-1:0] th_sub, ph_sub, th_sub_n, ph_sub_n;
    logic [15:0]      th_deg_n, ph_deg_n;
    logic             tick, th_pos, th_neg, ph_pos, ph_neg;
    logic             th_blk, th_up, th_dn, ph_up, ph_dn;

    // Tick detection, command decode, theta clamp and next phase/position.
    always_comb begin
        tick     = enable && (tick_cnt == CNT_LAST);
        th_pos   = (cmd_theta_pos == 2'b01) && (cmd_theta_neg != 2'b01);
        th_neg   = (cmd_theta_neg == 2'b01) && (cmd_theta_pos != 2'b01);
        ph_pos   = (cmd_phi_pos == 2'b01) && (cmd_phi_neg != 2'b01);
        ph_neg   = (cmd_phi_neg == 2'b01) && (cmd_phi_pos != 2'b01);
        th_blk   = tick && ((th_pos && (theta_actual == THETA_MAX)) ||
                            (th_neg && (theta_actual == 16'd0) && (th_sub == SUB_W'(0))));
        th_up    = tick && th_pos && !th_blk;
        th_dn    = tick && th_neg && !th_blk;
        ph_up    = tick && ph_pos;
        ph_dn    = tick && ph_neg;
        th_idx_n = th_idx;
        th_sub_n = th_sub;
        th_deg_n = theta_actual;
        ph_idx_n = ph_idx;
        ph_sub_n = ph_sub;
        ph_deg_n = phi_actual;

        if (th_up) begin
            th_idx_n = th_idx + IDX_W'(1);
            if (th_sub == SUB_LAST) begin
                th_sub_n = SUB_W'(0);
                th_deg_n = theta_actual + 16'd1;
            end else begin
                th_sub_n = th_sub + SUB_W'(1);
            end
        end else if (th_dn) begin
            th_idx_n = th_idx - IDX_W'(1);
            if (th_sub == SUB_W'(0)) begin
                th_sub_n = SUB_LAST;
                th_deg_n = theta_actual - 16'd1;
            end else begin
                th_sub_n = th_sub - SUB_W'(1);
            end
        end

        if (ph_up) begin
            ph_idx_n = ph_idx + IDX_W'(1);
            if (ph_sub == SUB_LAST) begin
                ph_sub_n = SUB_W'(0);
                ph_deg_n = (phi_actual == PHI_LAST) ? 16'd0 : phi_actual + 16'd1;
            end else begin
                ph_sub_n = ph_sub + SUB_W'(1);
            end
        end else if (ph_dn) begin
            ph_idx_n = ph_idx - IDX_W'(1);
            if (ph_sub == SUB_W'(0)) begin
                ph_sub_n = SUB_LAST;
                ph_deg_n = (phi_actual == 16'd0) ? PHI_LAST : phi_actual - 16'd1;
            end else begin
                ph_sub_n = ph_sub - SUB_W'(1);
            end
        end
    end

    // State and output registers; the tick counter parks at 0 while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt     <= '0;
            th_idx       <= '0;
            ph_idx       <= '0;
            th_sub       <= '0;
            ph_sub       <= '0;
            theta_actual <= '0;
            phi_actual   <= '0;
            coil_theta   <= 4'b0000;
            coil_phi     <= 4'b0000;
            step_theta   <= 1'b0;
            step_phi     <= 1'b0;
            limit_theta  <= 1'b0;
        end else begin
            tick_cnt     <= (!enable || tick) ? '0 : tick_cnt + CNT_W'(1);
            th_idx       <= th_idx_n;
            ph_idx       <= ph_idx_n;
            th_sub       <= th_sub_n;
            ph_sub       <= ph_sub_n;
            theta_actual <= th_deg_n;
            phi_actual   <= ph_deg_n;
            coil_theta   <= enable ? pattern(th_idx_n) : 4'b0000;
            coil_phi     <= enable ? pattern(ph_idx_n) : 4'b0000;
            step_theta   <= th_up || th_dn;
            step_phi     <= ph_up || ph_dn;
            if (tick) begin
                limit_theta <= th_blk;
            end
        end
    end

endmodule

// File: tb/tb_motor_step_driver.sv
// Directed bench for motor_step_driver (CLK_DIV=4, STEPS_PER_DEG=4);
// honours HALF_STEP_EN for the expected phase table.
module tb_motor_step_driver;

    localparam int unsigned CLK_DIV = 4;
`ifdef HALF_STEP_EN
    localparam int NPH = 8;
`else
    localparam int NPH = 4;
`endif

    logic        clk = 1'b0;
    logic        rst, enable;
    logic [1:0]  cmd_theta_pos, cmd_theta_neg, cmd_phi_pos, cmd_phi_neg;
    logic [3:0]  coil_theta, coil_phi;
    logic        step_theta, step_phi, limit_theta;
    logic [15:0] theta_actual, phi_actual;

    typedef struct {
        logic [3:0]  coil;
        logic [15:0] pos;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    motor_step_driver #(.CLK_DIV(CLK_DIV), .STEPS_PER_DEG(4)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cmd_theta_pos(cmd_theta_pos), .cmd_theta_neg(cmd_theta_neg),
        .cmd_phi_pos(cmd_phi_pos), .cmd_phi_neg(cmd_phi_neg),
        .coil_theta(coil_theta), .coil_phi(coil_phi),
        .step_theta(step_theta), .step_phi(step_phi),
        .theta_actual(theta_actual), .phi_actual(phi_actual),
        .limit_theta(limit_theta)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pat(input int i);
        int k;
        k = ((i % NPH) + NPH) % NPH;
`ifdef HALF_STEP_EN
        case (k)
            0: pat = 4'b1000;  1: pat = 4'b1100;  2: pat = 4'b0100;  3: pat = 4'b0110;
            4: pat = 4'b0010;  5: pat = 4'b0011;  6: pat = 4'b0001;  default: pat = 4'b1001;
        endcase
`else
        case (k)
            0: pat = 4'b1100;  1: pat = 4'b0110;  2: pat = 4'b0011;  default: pat = 4'b1001;
        endcase
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] coil, input logic [15:0] pos);
        exp_t e;
        e.coil = coil;
        e.pos  = pos;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next step pulse of one axis; ax=0 theta, ax=1 phi.
    task automatic wait_pulse(input bit ax, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        for (int i = 0; i < 5 * CLK_DIV && !hit; i++) begin
            @(negedge clk);
            cyc++;
            hit = ax ? step_phi : step_theta;
        end
        check(ax ? "pulse_phi" : "pulse_theta", 16'(hit), 16'd1);
    endtask

    // Wait for a step and compare against the oldest scoreboard entry.
    task automatic pop_check(input bit ax, input string tag, output int cyc);
        exp_t e;
        wait_pulse(ax, cyc);
        e = sb.pop_front();
        if (ax) begin
            check({tag, "_coil"}, 16'(coil_phi), 16'(e.coil));
            check({tag, "_pos"}, phi_actual, e.pos);
        end else begin
            check({tag, "_coil"}, 16'(coil_theta), 16'(e.coil));
            check({tag, "_pos"}, theta_actual, e.pos);
        end
    endtask

    // Run for a number of cycles and require no step pulse on either axis.
    task automatic check_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (step_theta || step_phi) pulses++;
        end
        check({tag, "_pulses"}, 16'(pulses), 16'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; enable = 1'b1;
        cmd_theta_pos = 2'b00; cmd_theta_neg = 2'b00;
        cmd_phi_pos = 2'b00;   cmd_phi_neg = 2'b00;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_coil_theta", 16'(coil_theta), 16'd0);
        check("rst_coil_phi", 16'(coil_phi), 16'd0);
        check("rst_theta", theta_actual, 16'd0);
        check("rst_phi", phi_actual, 16'd0);
        check("rst_steps", 16'({step_theta, step_phi, limit_theta}), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_coil_theta", 16'(coil_theta), 16'(pat(0)));
        check("post_rst_coil_phi", 16'(coil_phi), 16'(pat(0)));

        // theta forward 8 steps at 4-clk spacing
        cmd_theta_pos = 2'b01;
        for (int k = 1; k <= 8; k++) push_exp(pat(k), 16'(k / 4));
        for (int k = 1; k <= 8; k++) begin
            pop_check(1'b0, "th_fwd", cyc);
            if (k > 1) check("th_fwd_spacing", 16'(cyc), 16'(CLK_DIV));
            check("th_fwd_phi_idle", phi_actual, 16'd0);
        end

        // theta back 8 steps to 0.0
        cmd_theta_pos = 2'b00; cmd_theta_neg = 2'b01;
        for (int k = 1; k <= 8; k++) push_exp(pat(-k), (k <= 4) ? 16'd1 : 16'd0);
        for (int k = 1; k <= 8; k++) pop_check(1'b0, "th_rev", cyc);

        // lower clamp
        check_quiet("th_low_block", 10 * CLK_DIV);
        check("th_low_limit", 16'(limit_theta), 16'd1);
        check("th_low_coil", 16'(coil_theta), 16'(pat(0)));
        check("th_low_pos", theta_actual, 16'd0);
        cmd_theta_neg = 2'b00; cmd_theta_pos = 2'b01;
        push_exp(pat(1), 16'd0);
        pop_check(1'b0, "th_low_release", cyc);
        check("th_low_limit_clr", 16'(limit_theta), 16'd0);

        // run to 180 and hit the upper clamp
        for (int k = 0; k < 719; k++) wait_pulse(1'b0, cyc);
        check("th_at_180", theta_actual, 16'd180);
        check_quiet("th_high_block", 10 * CLK_DIV);
        check("th_high_limit", 16'(limit_theta), 16'd1);
        check("th_high_coil", 16'(coil_theta), 16'(pat(0)));
        cmd_theta_pos = 2'b00; cmd_theta_neg = 2'b01;
        push_exp(pat(-1), 16'd179);
        pop_check(1'b0, "th_high_release", cyc);
        check("th_high_limit_clr", 16'(limit_theta), 16'd0);
        cmd_theta_neg = 2'b00;

        // phi reverse through 0 -> 359 -> 358
        cmd_phi_neg = 2'b01;
        for (int k = 1; k <= 6; k++) push_exp(pat(-k), (k <= 4) ? 16'd359 : 16'd358);
        for (int k = 1; k <= 6; k++) pop_check(1'b1, "ph_rev", cyc);
        check("ph_rev_theta_held", theta_actual, 16'd179);

        // disable at phi index 2, then re-enable
        cmd_phi_neg = 2'b00; enable = 1'b0;
        @(negedge clk);
        check("dis_coil_phi", 16'(coil_phi), 16'd0);
        check("dis_coil_theta", 16'(coil_theta), 16'd0);
        cmd_phi_pos = 2'b01;
        check_quiet("dis_hold", 5 * CLK_DIV);
        check("dis_phi_pos", phi_actual, 16'd358);
        enable = 1'b1;
        @(negedge clk);
        check("en_coil_phi", 16'(coil_phi), 16'(pat(2)));
        check("en_coil_theta", 16'(coil_theta), 16'(pat(-1)));
        push_exp(pat(3), 16'd358);
        pop_check(1'b1, "en_first_step", cyc);
        check("en_first_latency", 16'(cyc + 1), 16'(CLK_DIV));

        // conflicting and invalid commands
        cmd_phi_neg = 2'b01;
        check_quiet("conflict_01_01", 10 * CLK_DIV);
        cmd_phi_pos = 2'b10; cmd_phi_neg = 2'b00;
        check_quiet("cmd_10", 10 * CLK_DIV);
        cmd_phi_pos = 2'b00; cmd_phi_neg = 2'b11;
        check_quiet("cmd_11", 10 * CLK_DIV);
        check("invalid_phi_pos", phi_actual, 16'd358);

        // reset mid-run
        cmd_phi_neg = 2'b00; cmd_phi_pos = 2'b01; cmd_theta_pos = 2'b01;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_coils", 16'({coil_theta, coil_phi}), 16'd0);
        check("mid_rst_pos", theta_actual | phi_actual, 16'd0);
        check("mid_rst_flags", 16'({step_theta, step_phi, limit_theta}), 16'd0);
        cmd_phi_pos = 2'b00; cmd_theta_pos = 2'b00;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_release_coil", 16'(coil_theta), 16'(pat(0)));
        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/motor_step_driver.md
MOTOR_STEP_DRIVER -- requirements
Module: motor_step_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clocks per step tick (minimum 2).
REQ-002 SHALL have parameter STEPS_PER_DEG, default 4, motor steps per degree of position (minimum 1).
REQ-003 SHALL have clk  input  1  clock, and rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have enable  input  1  1 = drive coils, 0 = de-energize and hold.
REQ-005 SHALL have cmd_theta_pos, cmd_theta_neg, cmd_phi_pos, cmd_phi_neg  input  2 each  direction requests; 2'b01 = active.
REQ-006 SHALL have coil_theta, coil_phi  output  4 each  registered coil phase drive.
REQ-007 SHALL have step_theta, step_phi  output  1 each  one-clk pulse per executed step.
REQ-008 SHALL have theta_actual, phi_actual  output  16 each  integer-degree position.
REQ-009 SHALL have limit_theta  output  1  high while theta_actual is 0 or 180 and the request is blocked.

Function
REQ-010 SHALL run a tick counter 0..CLK_DIV-1, wrapping to 0; the tick is the cycle in which the count equals CLK_DIV-1.
REQ-011 SHALL decode each axis per tick: pos = (cmd_pos==01 and cmd_neg!=01); neg = (cmd_neg==01 and cmd_pos!=01); otherwise stop; values 00/10/11 count as inactive.
REQ-012 SHALL sample commands only on the tick cycle; commands that change between ticks have no effect.
REQ-013 On a tick with pos, the axis SHALL advance its phase index +1 modulo N; with neg, -1 modulo N.
REQ-014 SHALL implement full-step (N=4) as index 0..3 = 1100, 0110, 0011, 1001.
REQ-015 SHALL hold a sub-degree counter 0..STEPS_PER_DEG-1 per axis; a pos step that wraps it to 0 SHALL increment degrees; a neg step that wraps it from 0 to STEPS_PER_DEG-1 SHALL decrement degrees.
REQ-016 phi SHALL wrap degrees 359 -> 0 on increment and 0 -> 359 on decrement.
REQ-017 theta SHALL block pos steps when theta_actual==180 and neg steps when theta_actual==0 with sub-degree 0; a blocked step leaves phase, position and coil unchanged, issues no step pulse, and sets limit_theta for that tick.
REQ-018 limit_theta SHALL clear on the next tick without a blocked request.
REQ-019 Coil, position and step outputs SHALL update on the clk edge ending the tick cycle, visible in the following cycle; step_x SHALL be high exactly that one cycle.
REQ-020 Each non-reset cycle, coil_x SHALL register enable ? pattern[index] : 4'b0000.
REQ-021 With enable low, the tick counter SHALL be held at 0, no steps SHALL occur, and the phase index and position SHALL be retained.
REQ-022 After enable rises, the first tick SHALL occur CLK_DIV cycles later, and the coils SHALL resume the retained index pattern one cycle after the rise.
REQ-023 The two axes SHALL step independently and may step on the same tick.

Reset
REQ-024 rst SHALL clear all of the following: tick counter, phase indices, sub-degree counters, theta_actual, phi_actual, coils (0000), step pulses and limit_theta.
REQ-025 rst SHALL take priority over enable and commands, including mid-step; one cycle after rst deasserts with enable=1, the coils SHALL read pattern[0].

Configuration
REQ-026 With HALF_STEP_EN defined, N SHALL be 8 with sequence 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001; each half-step SHALL count as one step for REQ-015.
REQ-027 Without HALF_STEP_EN, the block SHALL use the full-step sequence of REQ-014.

Verification (CLK_DIV=4, STEPS_PER_DEG=4, full-step unless noted)
REQ-028 Reset, enable=1, cmd_theta_pos=01 held -> coil_theta 1100,0110,0011,1001,1100 at 4-clk spacing; step_theta 1-clk pulses; theta_actual=1 after 4th step; phi untouched.
REQ-029 phi=0, sub-degree 0, cmd_phi_neg=01 -> after one step phi_actual=359, coil_phi=1001; after 4 more steps phi_actual=358.
REQ-030 theta driven to 180, cmd_theta_pos=01 -> no step pulse, coil frozen, limit_theta=1; switching to cmd_theta_neg=01 -> step resumes, limit_theta=0 on that tick.
REQ-031 cmd_phi_pos=01 and cmd_phi_neg=01 together, or cmd=10/11 -> no steps for 10 ticks, position unchanged.
REQ-032 enable dropped mid-run at index 2 -> coils 0000 next cycle, position held; re-enable -> coil 0011 next cycle, next step 4 clks later to 1001.
REQ-033 HALF_STEP_EN build, cmd_theta_pos=01 -> 8-pattern sequence, theta_actual=1 after 4 half-steps; rst asserted mid-sequence -> all outputs zero next cycle.
